// File: rtl/reg_file_pkg.sv
// Shared CPU register-file constants, also imported by the write-select mux and the control unit.
package reg_file_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_file.sv
// 32-entry register file: r0 hard-wired to zero, two combinational operand ports,
// one debug port, one synchronous write port and a saturating committed-write counter.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [CNT_W-1:0]      wr_count
);

  logic [NUM_REGS-1:1][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0][DATA_W-1:0] view;
  logic                            wr_en;
  logic [DATA_W-1:0]               rs_raw, rt_raw;

  assign wr_en = reg_write && (wr_addr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wr_en && wr_addr == REG_ADDR_W'(i)) regs[i] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         wr_count <= '0;
    else if (wr_en && ~&wr_count)    wr_count <= wr_count + 1'b1;
  end

  // Slot 0 is a constant so r0 can never leak X, whatever the address lines do.
  assign view     = {regs, {DATA_W{1'b0}}};
  assign rs_raw   = view[rs_addr];
  assign rt_raw   = view[rt_addr];
  assign dbg_data = view[dbg_addr];

  generate
    if (BYPASS) begin : g_byp
      // Only legal where wr_data does not depend on rs/rt_data, otherwise this is a loop.
      assign rs_data = (wr_en && rs_addr == wr_addr) ? wr_data : rs_raw;
      assign rt_data = (wr_en && rt_addr == wr_addr) ? wr_data : rt_raw;
    end else begin : g_nobyp
      assign rs_data = rs_raw;
      assign rt_data = rt_raw;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Directed test of reg_file: default build plus a CNT_W=4, BYPASS=1 build sharing clock and reset.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write, reg_write2;
  logic [4:0]  wr_addr, rs_addr, rt_addr, dbg_addr;
  logic [4:0]  wr_addr2, rs_addr2, rt_addr2, dbg_addr2;
  logic [31:0] wr_data, wr_data2;
  logic [31:0] rs_data, rt_data, dbg_data;
  logic [31:0] rs_data2, rt_data2, dbg_data2;
  logic [15:0] wr_count;
  logic [3:0]  wr_count2;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  reg_file #(.DATA_W(32), .BYPASS(1'b1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .reg_write(reg_write2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rs_addr(rs_addr2), .rt_addr(rt_addr2), .rs_data(rs_data2), .rt_data(rt_data2),
    .dbg_addr(dbg_addr2), .dbg_data(dbg_data2), .wr_count(wr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    rs_addr = a; rt_addr = a; dbg_addr = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    reg_write2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    rs_addr2 = '0; rt_addr2 = '0; dbg_addr2 = '0;
    tick();

    // reset state on every address
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      chk($sformatf("rst_rs%0d", a), rs_data, 32'h0);
      chk($sformatf("rst_rt%0d", a), rt_data, 32'h0);
      chk($sformatf("rst_dbg%0d", a), dbg_data, 32'h0);
    end
    chk("rst_cnt", 32'(wr_count), 32'd0);
    chk("rst_cnt2", 32'(wr_count2), 32'd0);
    rst = 1'b0;

    // write r8, read-before-edge returns old value
    reg_write = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF;
    rd(5'd8);
    chk("r8_pre", rs_data, 32'h0);
    tick();
    reg_write = 1'b0; #1;
    chk("r8_rs", rs_data, 32'hDEADBEEF);
    chk("r8_rt", rt_data, 32'hDEADBEEF);
    chk("r8_cnt", 32'(wr_count), 32'd1);

    // write to r0 is dropped and uncounted
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    tick();
    reg_write = 1'b0;
    rd(5'd0);
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_dbg", dbg_data, 32'h0);
    chk("r0_cnt", 32'(wr_count), 32'd1);

    // r5 = 0x11, then disabled write leaves it alone
    reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'h11;
    tick();
    chk("r5_cnt", 32'(wr_count), 32'd2);
    reg_write = 1'b0; wr_data = 32'hFFFFFFFF;
    tick();
    rd(5'd5);
    chk("r5_hold", rs_data, 32'h11);
    chk("r5_hold_cnt", 32'(wr_count), 32'd2);

    // split rs/rt addresses
    rs_addr = 5'd8; rt_addr = 5'd5; dbg_addr = 5'd8; #1;
    chk("split_rs", rs_data, 32'hDEADBEEF);
    chk("split_rt", rt_data, 32'h11);
    chk("split_dbg", dbg_data, 32'hDEADBEEF);

    // reset wins over simultaneous write
    rst = 1'b1; reg_write = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5;
    tick();
    rst = 1'b0; reg_write = 1'b0;
    rd(5'd31);
    chk("rstw_r31", rs_data, 32'h0);
    chk("rstw_cnt", 32'(wr_count), 32'd0);
    rd(5'd8);
    chk("rstw_r8", rs_data, 32'h0);

    reg_write = 1'b1; wr_addr = 5'd31; wr_data = 32'h1;
    tick();
    reg_write = 1'b0;
    rd(5'd31);
    chk("r31_rs", rs_data, 32'h1);
    chk("r31_rt", rt_data, 32'h1);
    chk("r31_cnt", 32'(wr_count), 32'd1);

    // saturating 4-bit counter on dut2
    reg_write2 = 1'b1; wr_addr2 = 5'd1;
    for (int i = 1; i <= 20; i++) begin
      wr_data2 = 32'(i);
      tick();
      if (i == 14) chk("sat_cnt14", 32'(wr_count2), 32'd14);
      if (i == 15) chk("sat_cnt15", 32'(wr_count2), 32'd15);
    end
    reg_write2 = 1'b0;
    dbg_addr2 = 5'd1; #1;
    chk("sat_cnt20", 32'(wr_count2), 32'd15);
    chk("sat_r1", dbg_data2, 32'd20);

    // bypass: read ports forward, debug port shows stored value
    reg_write2 = 1'b1; wr_addr2 = 5'd3; wr_data2 = 32'h55;
    rs_addr2 = 5'd3; rt_addr2 = 5'd3; dbg_addr2 = 5'd3; #1;
    chk("byp_rs", rs_data2, 32'h55);
    chk("byp_rt", rt_data2, 32'h55);
    chk("byp_dbg", dbg_data2, 32'h0);
    tick();
    reg_write2 = 1'b0; #1;
    chk("byp_dbg_post", dbg_data2, 32'h55);

    // bypass never forwards to r0
    reg_write2 = 1'b1; wr_addr2 = 5'd0; wr_data2 = 32'h77;
    rs_addr2 = 5'd0; rt_addr2 = 5'd1; #1;
    chk("byp_r0", rs_data2, 32'h0);
    chk("byp_other", rt_data2, 32'd20);
    tick();
    reg_write2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
